dct_stage_responder: RTL

- Datapath-side responder to the DCT control FSM.
- Consumes the stage enables `clr`, `start_mem`, `count_en`, `msps_en`, `cord_en` and `out_en`.
- Returns the handshake inputs the FSM waits on: `tally`, `msps_f`, `cord_F` and `out_f`.
- Also generates the input-memory read address and the output-stream index/valid that the load and output stages use.

---
 rtl/dct_stage_responder.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/dct_stage_responder.sv
`default_nettype none
// ============================================================================
// Module   : dct_stage_responder
// Purpose  : Datapath-side responder for the DCT control FSM. It counts
//            cycles (tally), creates the input-memory read address during the
//            load stage, times the butterfly and CORDIC stages, streams the
//            output index/valid, and flags enable-sequence violations.
// Revision : 1.0  initial release
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-low reset
//   clr        in   synchronous clear of all state (highest priority)
//   start_mem  in   load stage active
//   count_en   in   tally increment enable
//   msps_en    in   butterfly stage active
//   cord_en    in   CORDIC stage active
//   out_en     in   output stage active
//   tally      out  saturating cycle count since clr
//   mem_rd     out  input memory read strobe
//   mem_addr   out  input memory read address
//   msps_f     out  butterfly stage done (sticky)
//   cord_F     out  CORDIC stage done (sticky)
//   out_valid  out  output beat valid
//   out_idx    out  output coefficient index
//   out_f      out  output stage done (sticky)
//   proto_err  out  enable-sequence violation seen (sticky)
// ============================================================================
module dct_stage_responder #(
  parameter int CLOCK_LIM = 6,
  parameter int DCT_POINT = 16,
  parameter int ADDR_W    = 4,
  parameter int MSPS_CYC  = 20,
  parameter int CORD_CYC  = 12
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clr,
  input  logic                 start_mem,
  input  logic                 count_en,
  input  logic                 msps_en,
  input  logic                 cord_en,
  input  logic                 out_en,
  output logic [CLOCK_LIM-1:0] tally,
  output logic                 mem_rd,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic                 msps_f,
  output logic                 cord_F,
  output logic                 out_valid,
  output logic [ADDR_W-1:0]    out_idx,
  output logic                 out_f,
  output logic                 proto_err
);

  localparam logic [CLOCK_LIM-1:0] MSPS_LAST = CLOCK_LIM'(MSPS_CYC - 1);
  localparam logic [CLOCK_LIM-1:0] CORD_LAST = CLOCK_LIM'(CORD_CYC - 1);
  localparam logic [ADDR_W-1:0]    IDX_LAST  = ADDR_W'(DCT_POINT - 1);
  localparam logic [CLOCK_LIM-1:0] TALLY_MAX = '1;

  logic [CLOCK_LIM-1:0] tally_q,    tally_d;
  logic [CLOCK_LIM-1:0] msps_cnt_q, msps_cnt_d;
  logic [CLOCK_LIM-1:0] cord_cnt_q, cord_cnt_d;
  logic [ADDR_W-1:0]    out_idx_q,  out_idx_d;
  logic                 msps_f_q,   msps_f_d;
  logic                 cord_f_q,   cord_f_d;
  logic                 out_f_q,    out_f_d;
  logic                 perr_q,     perr_d;
  logic                 out_valid_w;

  // Combinational outputs are gated with reset so every output reads 0
  // while reset is held low, even if the enables are still driven.
  assign out_valid_w = out_en & ~out_f_q & reset;

  always_comb begin
    tally_d    = tally_q;
    msps_cnt_d = msps_cnt_q;
    msps_f_d   = msps_f_q;
    cord_cnt_d = cord_cnt_q;
    cord_f_d   = cord_f_q;
    out_idx_d  = out_idx_q;
    out_f_d    = out_f_q;
    perr_d     = perr_q;

    if (count_en && (tally_q != TALLY_MAX)) begin
      tally_d = tally_q + 1'b1;
    end

    // Stage counters stop at the terminal value; the done flag registers on
    // that same edge, so the flag rises exactly N edges after enable.
    if (msps_en && !msps_f_q) begin
      if (msps_cnt_q == MSPS_LAST) begin
        msps_f_d = 1'b1;
      end else begin
        msps_cnt_d = msps_cnt_q + 1'b1;
      end
    end

    if (cord_en && !cord_f_q) begin
      if (cord_cnt_q == CORD_LAST) begin
        cord_f_d = 1'b1;
      end else begin
        cord_cnt_d = cord_cnt_q + 1'b1;
      end
    end

    if (out_valid_w) begin
      if (out_idx_q == IDX_LAST) begin
        out_f_d = 1'b1;
      end else begin
        out_idx_d = out_idx_q + 1'b1;
      end
    end

    if ((cord_en && !msps_f_q) || (out_en && !cord_f_q) || (msps_en && cord_en)) begin
      perr_d = 1'b1;
    end

    if (clr) begin
      tally_d    = '0;
      msps_cnt_d = '0;
      msps_f_d   = 1'b0;
      cord_cnt_d = '0;
      cord_f_d   = 1'b0;
      out_idx_d  = '0;
      out_f_d    = 1'b0;
      perr_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tally_q    <= '0;
      msps_cnt_q <= '0;
      msps_f_q   <= 1'b0;
      cord_cnt_q <= '0;
      cord_f_q   <= 1'b0;
      out_idx_q  <= '0;
      out_f_q    <= 1'b0;
      perr_q     <= 1'b0;
    end else begin
      tally_q    <= tally_d;
      msps_cnt_q <= msps_cnt_d;
      msps_f_q   <= msps_f_d;
      cord_cnt_q <= cord_cnt_d;
      cord_f_q   <= cord_f_d;
      out_idx_q  <= out_idx_d;
      out_f_q    <= out_f_d;
      perr_q     <= perr_d;
    end
  end

  assign tally     = tally_q;
  assign mem_rd    = start_mem & reset;
  assign mem_addr  = mem_rd ? tally_q[ADDR_W-1:0] : '0;
  assign msps_f    = msps_f_q;
  assign cord_F    = cord_f_q;
  assign out_valid = out_valid_w;
  assign out_idx   = out_idx_q;
  assign out_f     = out_f_q;
  assign proto_err = perr_q;

endmodule
`default_nettype wire
